// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-port responder: word RAM plus MMIO page (TX FIFO, status,
//            cycle counter, sticky halt). One-cycle registered read data.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int unsigned TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] write_mem_data,
    input  logic        write_enable,
    output logic [31:0] dmem_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] c_OFF_TXDATA = 2'd0;
    localparam logic [1:0] c_OFF_STATUS = 2'd1;
    localparam logic [1:0] c_OFF_CYCLE  = 2'd2;
    localparam logic [1:0] c_OFF_HALT   = 2'd3;

    logic [31:0] r_mem  [RAM_WORDS];
    logic [7:0]  r_fifo [TX_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic        r_ovf;
    logic [31:0] r_cycle;
    logic        r_halt;

    logic        w_mmio, w_ram_hit, w_full, w_empty;
    logic        w_pop, w_push_req, w_push, w_ovf_set;
    logic        w_wr_status, w_wr_cycle, w_wr_halt;
    logic [1:0]  w_off;
    logic [AW-1:0] w_ram_idx;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    assign w_unused_addr = ^dmem_addr[1:0];

    assign w_mmio    = (dmem_addr[31:4] == MMIO_BASE[31:4]);
    assign w_off     = dmem_addr[3:2];
    assign w_ram_hit = !w_mmio && ({2'b00, dmem_addr[31:2]} < 32'(RAM_WORDS));
    assign w_ram_idx = dmem_addr[AW+1:2];

    assign w_full  = (r_count == CW'(TX_DEPTH));
    assign w_empty = (r_count == '0);

    assign w_pop       = !w_empty && tx_ready;
    assign w_push_req  = write_enable && w_mmio && (w_off == c_OFF_TXDATA);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_set   = w_push_req && w_full && !w_pop;
    assign w_wr_status = write_enable && w_mmio && (w_off == c_OFF_STATUS);
    assign w_wr_cycle  = write_enable && w_mmio && (w_off == c_OFF_CYCLE);
    assign w_wr_halt   = write_enable && w_mmio && (w_off == c_OFF_HALT);

    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign halt     = r_halt;

    always_comb begin
        w_rdata = 32'h0;
        if (w_mmio) begin
            case (w_off)
                c_OFF_STATUS: w_rdata = {29'b0, r_ovf, w_empty, w_full};
                c_OFF_CYCLE:  w_rdata = r_cycle;
                c_OFF_HALT:   w_rdata = {31'b0, r_halt};
                default:      w_rdata = 32'h0;
            endcase
        end else if (w_ram_hit) begin
            w_rdata = r_mem[w_ram_idx];
        end
    end

    // Storage arrays carry no reset; FIFO slots are only visible when counted.
    always_ff @(posedge clk) begin
        if (write_enable && w_ram_hit) begin
            r_mem[w_ram_idx] <= write_mem_data;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= write_mem_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_data <= 32'h0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_cycle   <= 32'h0;
            r_halt    <= 1'b0;
        end else begin
            dmem_data <= w_rdata;

            if (w_wr_cycle) begin
                r_cycle <= write_mem_data;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end

            if (w_wr_halt) begin
                r_halt <= 1'b1;
            end

            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && write_mem_data[2]) begin
                r_ovf <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Scoreboard bench for dmem_responder read path, TX stream and MMIO.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam logic [31:0] c_TXA = 32'hFFFF_0000;
    localparam logic [31:0] c_STA = 32'hFFFF_0004;
    localparam logic [31:0] c_CYA = 32'hFFFF_0008;
    localparam logic [31:0] c_HLA = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dmem_addr;
    logic [31:0] write_mem_data;
    logic        write_enable;
    logic [31:0] dmem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_exp[$];
    bit          q_chk[$];
    string       q_tag[$];
    logic [7:0]  q_tx[$];

    dmem_responder #(
        .RAM_WORDS (256),
        .MMIO_BASE (32'hFFFF_0000),
        .TX_DEPTH  (4)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .dmem_addr      (dmem_addr),
        .write_mem_data (write_mem_data),
        .write_enable   (write_enable),
        .dmem_data      (dmem_data),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%08h required=%08h", tag, act, exp);
        end
    endtask

    // One clock: observe TX handshake at the edge, then retire the read issued this cycle.
    task automatic step();
        logic       v, r;
        logic [7:0] d;
        logic [7:0] e;
        logic [31:0] x;
        bit         c;
        string      t;
        v = tx_valid;
        r = tx_ready;
        d = tx_data;
        @(posedge clk);
        #1;
        if (v && r) begin
            if (q_tx.size() == 0) begin
                check_val("tx_unexpected_byte", {24'b0, d}, 32'hFFFF_FFFF);
            end else begin
                e = q_tx.pop_front();
                check_val("tx_byte", {24'b0, d}, {24'b0, e});
            end
        end
        x = q_exp.pop_front();
        c = q_chk.pop_front();
        t = q_tag.pop_front();
        if (c) check_val(t, dmem_data, x);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input bit c, input logic [31:0] e, input string t);
        dmem_addr      = a;
        write_mem_data = d;
        write_enable   = we;
        q_exp.push_back(e);
        q_chk.push_back(c);
        q_tag.push_back(t);
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(a, d, 1'b1, 1'b0, 32'h0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
        drive(a, 32'h0, 1'b0, 1'b1, e, t);
    endtask

    task automatic idle();
        drive(32'h10, 32'h0, 1'b0, 1'b0, 32'h0, "");
    endtask

    initial begin
        reset          = 1'b1;
        tx_ready       = 1'b0;
        dmem_addr      = 32'h0;
        write_mem_data = 32'h0;
        write_enable   = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_val("rst_dmem_data", dmem_data, 32'h0);
        check_val("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_val("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check_val("rst_halt", {31'b0, halt}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // RAM read/write, out-of-range, read-before-write
        wr(32'h0, 32'h0BAD_0000);
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
        rd(32'h13, 32'hDEAD_BEEF, "ram_rd_unaligned");
        rd(32'h400, 32'h0, "ram_oor_rd");
        wr(32'h400, 32'h5555_5555);
        rd(32'h0, 32'h0BAD_0000, "ram_oor_wr_no_alias");
        rd(32'h400, 32'h0, "ram_oor_after_wr");
        drive(32'h10, 32'h1234_5678, 1'b1, 1'b1, 32'hDEAD_BEEF, "ram_read_before_write");
        rd(32'h10, 32'h1234_5678, "ram_new_word");
        wr(32'h10, 32'hDEAD_BEEF);

        // Overflow with consumer stalled, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(c_TXA, 32'h41 + 32'(i), 1'b1, 1'b1, 32'h0, "txdata_reads_zero");
            if (i < 4) q_tx.push_back(8'(8'h41 + i));
        end
        check_val("tx_valid_full", {31'b0, tx_valid}, 32'h1);
        check_val("tx_head_stall", {24'b0, tx_data}, 32'h41);
        rd(c_STA, 32'h5, "status_full_ovf");
        check_val("tx_head_stall2", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        repeat (5) drive(c_STA, 32'h0, 1'b0, 1'b0, 32'h0, "");
        rd(c_STA, 32'h6, "status_drained_ovf");
        check_val("tx_q_drained1", 32'(q_tx.size()), 32'h0);
        drive(c_STA, 32'h4, 1'b1, 1'b1, 32'h6, "status_before_clear");
        rd(c_STA, 32'h2, "status_ovf_cleared");

        // Push and pop on the same cycle while full
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_tx.push_back(8'(8'hA0 + i));
            drive(c_TXA, 32'hA0 + 32'(i), 1'b1, 1'b1, 32'h0, "txdata_reads_zero");
        end
        rd(c_STA, 32'h1, "status_full");
        tx_ready = 1'b1;
        q_tx.push_back(8'hA4);
        drive(c_TXA, 32'hA4, 1'b1, 1'b1, 32'h0, "txdata_reads_zero");
        rd(c_STA, 32'h1, "status_full_after_pushpop");
        repeat (5) idle();
        rd(c_STA, 32'h2, "status_empty_no_ovf");
        check_val("tx_q_drained2", 32'(q_tx.size()), 32'h0);
        tx_ready = 1'b0;

        // Cycle counter load and wrap
        wr(c_CYA, 32'hFFFF_FFFE);
        idle();
        rd(c_CYA, 32'hFFFF_FFFF, "cycle_pre_wrap");
        rd(c_CYA, 32'h0, "cycle_wrap");

        // Sticky halt
        check_val("halt_before_write", {31'b0, halt}, 32'h0);
        wr(c_HLA, 32'h0);
        check_val("halt_set", {31'b0, halt}, 32'h1);
        rd(c_HLA, 32'h1, "halt_rd");
        rd(32'h10, 32'hDEAD_BEEF, "ram_while_halted");

        // Asynchronous reset with bytes queued
        wr(c_TXA, 32'h61);
        wr(c_TXA, 32'h62);
        rd(32'h10, 32'hDEAD_BEEF, "ram_before_reset");
        #2 reset = 1'b0;
        #1;
        check_val("async_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_val("async_rst_tx_data", {24'b0, tx_data}, 32'h0);
        check_val("async_rst_dmem_data", dmem_data, 32'h0);
        check_val("async_rst_halt", {31'b0, halt}, 32'h0);
        #1 reset = 1'b1;
        rd(c_CYA, 32'h0, "cycle_after_reset");
        rd(c_STA, 32'h2, "status_after_reset");
        rd(32'h10, 32'hDEAD_BEEF, "ram_kept_over_reset");
        rd(c_HLA, 32'h0, "halt_rd_after_reset");
        check_val("tx_q_final", 32'(q_tx.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
